// File: rtl/sm_pkg.sv
// Shared opcodes, error codes and default sizing for the stack machine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm_pkg;

  localparam int SM_DEPTH = 8;
  localparam int SM_DW    = 20;
  localparam int SM_PCW   = 10;
  localparam int IMMW     = 10;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_STACK_OVF = 3'd1;
  localparam logic [2:0] ERR_STACK_UNF = 3'd2;
  localparam logic [2:0] ERR_ARITH_OVF = 3'd3;
  localparam logic [2:0] ERR_INVALID   = 3'd4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2
  } alu_op_e;

endpackage

// File: rtl/sm_alu.sv
// Signed add/sub/mul on two DW-bit operands, wrapped result plus overflow flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result follows the inputs every cycle.
module sm_alu
  import sm_pkg::*;
#(
  parameter int DW = SM_DW
) (
  input  alu_op_e               op_i,
  input  logic signed [DW-1:0]  a_i,
  input  logic signed [DW-1:0]  b_i,
  output logic        [DW-1:0]  res_o,
  output logic                  ovf_o
);

  logic [DW:0]     sum;
  logic [2*DW-1:0] prod;

  // Overflow means the exact result does not fit back into DW signed bits.
  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    sum   = '0;
    prod  = '0;
    case (op_i)
      ALU_ADD: begin
        sum   = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
        res_o = sum[DW-1:0];
        ovf_o = sum[DW] ^ sum[DW-1];
      end
      ALU_SUB: begin
        sum   = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};
        res_o = sum[DW-1:0];
        ovf_o = sum[DW] ^ sum[DW-1];
      end
      ALU_MUL: begin
        prod  = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
        res_o = prod[DW-1:0];
        ovf_o = (prod[2*DW-1:DW-1] != {(DW+1){prod[DW-1]}});
      end
      default: begin
        res_o = '0;
        ovf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/stack_machine.sv
// Single-issue stack machine: one instruction per clock from external memory at pc.
// Latency: result/err combinational in the issue cycle; stack, pc and fin update at next edge.
// Backpressure: none; fetch stops only when fin is set (HALT or last address).
module stack_machine
  import sm_pkg::*;
#(
  parameter int DEPTH = SM_DEPTH,
  parameter int DW    = SM_DW,
  parameter int PCW   = SM_PCW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [12:0]    instr,
  output logic [PCW-1:0] pc,
  output logic           d_valid,
  output logic [DW-1:0]  out_data,
  output logic [2:0]     err_code,
  output logic           fin
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);
  localparam logic [PCW-1:0] PC_LAST = '1;

  logic [DW-1:0]  stk_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           fin_q, fin_d;

  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [DW-1:0]  wr_dat;

  logic [2:0]     opcode;
  logic [DW-1:0]  imm_sext;
  logic [IW-1:0]  top_idx, sec_idx;
  logic [DW-1:0]  top_val, sec_val;
  alu_op_e        alu_op;
  logic [DW-1:0]  alu_res;
  logic           alu_ovf;

  assign opcode   = instr[12:10];
  assign imm_sext = {{(DW-IMMW){instr[IMMW-1]}}, instr[IMMW-1:0]};

  // Index arithmetic may wrap when the stack is shallow; every use below is guarded by sp.
  assign top_idx = IW'(sp_q - SPW'(1));
  assign sec_idx = IW'(sp_q - SP_TWO);
  assign top_val = (sp_q != '0) ? stk_q[top_idx] : '0;
  assign sec_val = stk_q[sec_idx];

  // Map the instruction opcode onto the ALU operation.
  always_comb begin
    alu_op = ALU_MUL;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      default: alu_op = ALU_MUL;
    endcase
  end

  sm_alu #(.DW(DW)) u_alu (
    .op_i  (alu_op),
    .a_i   (sec_val),
    .b_i   (top_val),
    .res_o (alu_res),
    .ovf_o (alu_ovf)
  );

  // Decode, error classification and next-state; rejected instructions leave the stack alone.
  always_comb begin
    d_valid  = 1'b0;
    out_data = '0;
    err_code = ERR_OK;
    sp_d     = sp_q;
    pc_d     = pc_q;
    fin_d    = fin_q;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_dat   = '0;
    if (rst_n && !fin_q) begin
      d_valid = 1'b1;
      if (pc_q == PC_LAST) begin
        fin_d = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
      case (opcode)
        OP_PUSH: begin
          if (sp_q == SP_FULL) begin
            err_code = ERR_STACK_OVF;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = IW'(sp_q);
            wr_dat   = imm_sext;
            sp_d     = sp_q + 1'b1;
            out_data = imm_sext;
          end
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          if (sp_q < SP_TWO) begin
            err_code = ERR_STACK_UNF;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = sec_idx;
            wr_dat   = alu_res;
            sp_d     = sp_q - 1'b1;
            out_data = alu_res;
            if (alu_ovf) err_code = ERR_ARITH_OVF;
          end
        end
        OP_HALT: begin
          out_data = top_val;
          fin_d    = 1'b1;
        end
        default: begin
          err_code = ERR_INVALID;
        end
      endcase
    end
  end

  // State registers: synchronous active-low reset empties the stack and restarts at pc 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= '0;
      sp_q  <= '0;
      fin_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      fin_q <= fin_d;
      if (wr_en) stk_q[wr_idx] <= wr_dat;
    end
  end

  assign pc  = pc_q;
  assign fin = fin_q;

endmodule

// File: tb/tb_stack_machine.sv
// Self-checking bench for stack_machine using a per-instruction scoreboard.
// Latency: outputs sampled 3 time units after instr is driven, well before the next edge.
// Backpressure: n/a.
module tb_stack_machine;
  import sm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] instr = '0;
  logic [9:0]  pc;
  logic        d_valid;
  logic [19:0] out_data;
  logic [2:0]  err_code;
  logic        fin;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        vld;
    logic [19:0] dat;
    logic [2:0]  err;
    logic [9:0]  pc;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] exp_pc = '0;

  stack_machine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .pc       (pc),
    .d_valid  (d_valid),
    .out_data (out_data),
    .err_code (err_code),
    .fin      (fin)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    instr = {OP_PUSH, 10'd0};
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_pc = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr = {OP_PUSH, 10'd5};
    @(posedge clk); #1;
    tests_run++;
    if ({d_valid, out_data, err_code} !== {1'b0, 20'd0, ERR_OK}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got vld=%0b dat=%0d err=%0d, want 0/0/0", d_valid, out_data, err_code);
    end
    rst_n = 1'b1;
    exp_pc = '0;
    #1;
    tests_run++;
    if ({pc, fin, d_valid} !== {10'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got pc=%0d fin=%0b vld=%0b, want pc=0 fin=0 vld=1", pc, fin, d_valid);
    end
  endtask

  task automatic test_push_add();
    logic [12:0] prog [3] = '{{OP_PUSH, 10'd3}, {OP_PUSH, 10'd5}, {OP_ADD, 10'd0}};
    logic [19:0] edat [3] = '{20'd3, 20'd5, 20'd8};
    exp_t e, g;
    for (int i = 0; i < 3; i++) begin
      e.vld = 1'b1; e.dat = edat[i]; e.err = ERR_OK; e.pc = exp_pc;
      sb.push_back(e);
      instr = prog[i];
      #3;
      g = sb.pop_front();
      tests_run++;
      if ({d_valid, out_data, err_code, pc} !== {g.vld, g.dat, g.err, g.pc}) begin
        tests_failed++;
        $display("FAIL push_add[%0d]: got vld=%0b dat=%0d err=%0d pc=%0d, want vld=%0b dat=%0d err=%0d pc=%0d",
                 i, d_valid, $signed(out_data), err_code, pc, g.vld, $signed(g.dat), g.err, g.pc);
      end
      @(posedge clk); #1;
      exp_pc++;
    end
  endtask

  task automatic test_sub_mul();
    logic [12:0] prog [5] = '{{OP_PUSH, 10'd7}, {OP_PUSH, 10'h3FE}, {OP_SUB, 10'd0},
                              {OP_PUSH, 10'd10}, {OP_MUL, 10'd0}};
    logic [19:0] edat [5] = '{20'd7, 20'hFFFFE, 20'd9, 20'd10, 20'd90};
    exp_t e, g;
    for (int i = 0; i < 5; i++) begin
      e.vld = 1'b1; e.dat = edat[i]; e.err = ERR_OK; e.pc = exp_pc;
      sb.push_back(e);
      instr = prog[i];
      #3;
      g = sb.pop_front();
      tests_run++;
      if ({d_valid, out_data, err_code, pc} !== {g.vld, g.dat, g.err, g.pc}) begin
        tests_failed++;
        $display("FAIL sub_mul[%0d]: got vld=%0b dat=%0d err=%0d pc=%0d, want vld=%0b dat=%0d err=%0d pc=%0d",
                 i, d_valid, $signed(out_data), err_code, pc, g.vld, $signed(g.dat), g.err, g.pc);
      end
      @(posedge clk); #1;
      exp_pc++;
    end
  endtask

  task automatic test_underflow();
    logic [12:0] prog [4] = '{{OP_ADD, 10'd0}, {OP_PUSH, 10'd1}, {OP_SUB, 10'd0}, {OP_MUL, 10'd0}};
    logic [19:0] edat [4] = '{20'd0, 20'd1, 20'd0, 20'd0};
    logic [2:0]  eerr [4] = '{ERR_STACK_UNF, ERR_OK, ERR_STACK_UNF, ERR_STACK_UNF};
    exp_t e, g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e.vld = 1'b1; e.dat = edat[i]; e.err = eerr[i]; e.pc = exp_pc;
      sb.push_back(e);
      instr = prog[i];
      #3;
      g = sb.pop_front();
      tests_run++;
      if ({d_valid, out_data, err_code, pc} !== {g.vld, g.dat, g.err, g.pc}) begin
        tests_failed++;
        $display("FAIL underflow[%0d]: got vld=%0b dat=%0d err=%0d pc=%0d, want vld=%0b dat=%0d err=%0d pc=%0d",
                 i, d_valid, $signed(out_data), err_code, pc, g.vld, $signed(g.dat), g.err, g.pc);
      end
      @(posedge clk); #1;
      exp_pc++;
    end
  endtask

  // Nine pushes into an 8-deep stack, then drain with ADDs to prove exactly 8 entries were kept.
  task automatic test_stack_overflow();
    logic [12:0] prog [17];
    logic [19:0] edat [17];
    logic [2:0]  eerr [17];
    exp_t e, g;
    for (int i = 0; i < 17; i++) begin
      if (i < 9) begin
        prog[i] = {OP_PUSH, 10'd1};
        edat[i] = (i < 8) ? 20'd1 : 20'd0;
        eerr[i] = (i < 8) ? ERR_OK : ERR_STACK_OVF;
      end else begin
        prog[i] = {OP_ADD, 10'd0};
        edat[i] = (i < 16) ? 20'(i - 7) : 20'd0;
        eerr[i] = (i < 16) ? ERR_OK : ERR_STACK_UNF;
      end
    end
    do_reset();
    for (int i = 0; i < 17; i++) begin
      e.vld = 1'b1; e.dat = edat[i]; e.err = eerr[i]; e.pc = exp_pc;
      sb.push_back(e);
      instr = prog[i];
      #3;
      g = sb.pop_front();
      tests_run++;
      if ({d_valid, out_data, err_code, pc} !== {g.vld, g.dat, g.err, g.pc}) begin
        tests_failed++;
        $display("FAIL stack_ovf[%0d]: got vld=%0b dat=%0d err=%0d pc=%0d, want vld=%0b dat=%0d err=%0d pc=%0d",
                 i, d_valid, $signed(out_data), err_code, pc, g.vld, $signed(g.dat), g.err, g.pc);
      end
      @(posedge clk); #1;
      exp_pc++;
    end
  endtask

  // 511^2 = 261121 fits; 511*261121 = 133432831 wraps to 263679; 511*263679 wraps to 522241.
  task automatic test_arith_ovf();
    logic [12:0] prog [7] = '{{OP_PUSH, 10'd511}, {OP_PUSH, 10'd511}, {OP_PUSH, 10'd511},
                              {OP_PUSH, 10'd511}, {OP_MUL, 10'd0}, {OP_MUL, 10'd0}, {OP_MUL, 10'd0}};
    logic [19:0] edat [7] = '{20'd511, 20'd511, 20'd511, 20'd511, 20'd261121, 20'd263679, 20'd522241};
    logic [2:0]  eerr [7] = '{ERR_OK, ERR_OK, ERR_OK, ERR_OK, ERR_OK, ERR_ARITH_OVF, ERR_ARITH_OVF};
    exp_t e, g;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      e.vld = 1'b1; e.dat = edat[i]; e.err = eerr[i]; e.pc = exp_pc;
      sb.push_back(e);
      instr = prog[i];
      #3;
      g = sb.pop_front();
      tests_run++;
      if ({d_valid, out_data, err_code, pc} !== {g.vld, g.dat, g.err, g.pc}) begin
        tests_failed++;
        $display("FAIL arith_ovf[%0d]: got vld=%0b dat=%0d err=%0d pc=%0d, want vld=%0b dat=%0d err=%0d pc=%0d",
                 i, d_valid, $signed(out_data), err_code, pc, g.vld, $signed(g.dat), g.err, g.pc);
      end
      @(posedge clk); #1;
      exp_pc++;
    end
  endtask

  task automatic test_invalid_halt();
    logic [12:0] prog [5] = '{{OP_PUSH, 10'd42}, {3'b100, 10'd0}, {3'b101, 10'd3},
                              {3'b110, 10'd9}, {OP_HALT, 10'd0}};
    logic [19:0] edat [5] = '{20'd42, 20'd0, 20'd0, 20'd0, 20'd42};
    logic [2:0]  eerr [5] = '{ERR_OK, ERR_INVALID, ERR_INVALID, ERR_INVALID, ERR_OK};
    exp_t e, g;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e.vld = 1'b1; e.dat = edat[i]; e.err = eerr[i]; e.pc = exp_pc;
      sb.push_back(e);
      instr = prog[i];
      #3;
      g = sb.pop_front();
      tests_run++;
      if ({d_valid, out_data, err_code, pc} !== {g.vld, g.dat, g.err, g.pc}) begin
        tests_failed++;
        $display("FAIL invalid_halt[%0d]: got vld=%0b dat=%0d err=%0d pc=%0d, want vld=%0b dat=%0d err=%0d pc=%0d",
                 i, d_valid, $signed(out_data), err_code, pc, g.vld, $signed(g.dat), g.err, g.pc);
      end
      @(posedge clk); #1;
      exp_pc++;
    end
    for (int i = 0; i < 3; i++) begin
      instr = {OP_PUSH, 10'd1};
      #3;
      tests_run++;
      if ({fin, d_valid, out_data, err_code, pc} !== {1'b1, 1'b0, 20'd0, ERR_OK, exp_pc}) begin
        tests_failed++;
        $display("FAIL halted[%0d]: got fin=%0b vld=%0b dat=%0d err=%0d pc=%0d, want fin=1 vld=0 dat=0 err=0 pc=%0d",
                 i, fin, d_valid, out_data, err_code, pc, exp_pc);
      end
      @(posedge clk); #1;
    end
    do_reset();
    instr = {OP_HALT, 10'd0};
    #3;
    tests_run++;
    if ({fin, d_valid, out_data, err_code, pc} !== {1'b0, 1'b1, 20'd0, ERR_OK, 10'd0}) begin
      tests_failed++;
      $display("FAIL restart_halt_empty: got fin=%0b vld=%0b dat=%0d err=%0d pc=%0d, want fin=0 vld=1 dat=0 err=0 pc=0",
               fin, d_valid, out_data, err_code, pc);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({fin, pc} !== {1'b1, 10'd1}) begin
      tests_failed++;
      $display("FAIL halt_empty_fin: got fin=%0b pc=%0d, want fin=1 pc=1", fin, pc);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    instr = {OP_PUSH, 10'd9};
    @(posedge clk); #1;
    instr = {OP_PUSH, 10'd9};
    @(posedge clk); #1;
    do_reset();
    instr = {OP_ADD, 10'd0};
    #3;
    tests_run++;
    if ({d_valid, out_data, err_code, pc} !== {1'b1, 20'd0, ERR_STACK_UNF, 10'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset: got vld=%0b dat=%0d err=%0d pc=%0d, want vld=1 dat=0 err=2 pc=0",
               d_valid, out_data, err_code, pc);
    end
    @(posedge clk); #1;
  endtask

  // Run to the last address; the final instruction executes, then fin sets and pc holds at 1023.
  task automatic test_pc_end();
    logic [12:0] last [2] = '{{OP_PUSH, 10'd1}, {OP_HALT, 10'd0}};
    logic [19:0] edat [2] = '{20'd1, 20'd0};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 1023; i++) begin
        instr = {3'b100, 10'd0};
        @(posedge clk); #1;
      end
      instr = last[k];
      #3;
      tests_run++;
      if ({d_valid, out_data, err_code, pc, fin} !== {1'b1, edat[k], ERR_OK, 10'd1023, 1'b0}) begin
        tests_failed++;
        $display("FAIL pc_last[%0d]: got vld=%0b dat=%0d err=%0d pc=%0d fin=%0b, want vld=1 dat=%0d err=0 pc=1023 fin=0",
                 k, d_valid, out_data, err_code, pc, fin, edat[k]);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({fin, d_valid, pc} !== {1'b1, 1'b0, 10'd1023}) begin
        tests_failed++;
        $display("FAIL pc_end_fin[%0d]: got fin=%0b vld=%0b pc=%0d, want fin=1 vld=0 pc=1023", k, fin, d_valid, pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_add();
    test_sub_mul();
    test_underflow();
    test_stack_overflow();
    test_arith_ovf();
    test_invalid_halt();
    test_mid_reset();
    test_pc_end();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
